blink_period_ctrl: RTL and testbench
====================================

# blink_period_ctrl

Upstream control stage for `led_blink_module`. It turns two raw push-buttons into the 32-bit `timer_upper_bound` blink half-period, in milliseconds. It synchronises and debounces both buttons, steps the period up or down with saturation, and auto-repeats while a button is held. Pressing both buttons restores the initial period.

## Interface
Parameters:
- `TICKS_PER_MS`, 100000 — clk cycles per millisecond tick; must match the downstream multiplier.
- `DEBOUNCE_MS`, 20 — ms of stable input required before the debounced level changes.
- `REPEAT_DELAY_MS`, 500 — hold time before auto-repeat starts.
- `REPEAT_RATE_MS`, 100 — interval between auto-repeat steps.
- `PERIOD_MIN`, 50 / `PERIOD_MAX`, 2000 / `PERIOD_STEP`, 50 / `PERIOD_INIT`, 500 — period bounds, step size and reset value, all in ms.

Ports:
- `clk`  in  1  — single clock.
- `reset`  in  1  — synchronous, active-high.
- `btn_up`  in  1  — raw asynchronous button input, active-high.
- `btn_down`  in  1  — raw asynchronous button input, active-high.
- `timer_upper_bound`  out  32  — current period in ms; connects directly to `led_blink_module.timer_upper_bound`.
- `period_changed`  out  1  — one-cycle pulse in the cycle `timer_upper_bound` takes a new value.
- `at_limit`  out  1  — high while `timer_upper_bound` equals `PERIOD_MIN` or `PERIOD_MAX`.

## Operation
- **Synchroniser:** each raw button passes through a 2-flop synchroniser.
- **Tick generator:** counter runs 0..`TICKS_PER_MS`-1. `ms_tick` is high for one cycle when the count equals `TICKS_PER_MS`-1, then the counter wraps to 0.
- **Debouncer (per button):**
  - The stability counter advances on `ms_tick` while the synced input differs from the debounced level.
  - Any cycle where the synced input equals the debounced level clears the counter.
  - When the counter reaches `DEBOUNCE_MS`, the debounced level flips and the counter clears.
  - The block derives one-cycle rise/fall strobes from the debounced levels.
- **FSM states:** IDLE, HOLD_DELAY, REPEAT, WAIT_RELEASE.
  - IDLE, up-rise with down low: apply +STEP, clear the hold counter, go to HOLD_DELAY(dir=up). Down-rise with up low: same with −STEP.
  - Any state, both debounced levels high: load `PERIOD_INIT`, go to WAIT_RELEASE. Both rises in the same cycle count as "both high".
  - HOLD_DELAY: the hold counter counts `ms_tick`. At `REPEAT_DELAY_MS`, apply a step in the latched direction, clear the counter, go to REPEAT.
  - REPEAT: apply a step every `REPEAT_RATE_MS` ticks.
  - HOLD_DELAY/REPEAT: if the latched button's debounced level falls, go to IDLE with no step.
  - WAIT_RELEASE: stay until both debounced levels are low, then go to IDLE. No steps are taken in this state.
- **Arithmetic:**
  - Up step: `min(period + STEP, PERIOD_MAX)`.
  - Down step: if `period < PERIOD_MIN + STEP` the result is `PERIOD_MIN`, else `period − STEP`. Never wraps.
  - Internal sums are 33 bits wide.
- **Change pulse:** `period_changed` fires only when the new value differs from the old one. A step at a limit, or an init-restore when already at init, produces no pulse.

## Timing
- **Reset values:** `timer_upper_bound`=`PERIOD_INIT`, `period_changed`=0, `at_limit`=(`PERIOD_INIT`∈{MIN,MAX}). FSM=IDLE, all counters 0, synchroniser flops and debounced levels 0.
- **Reset mid-hold:** aborts all activity on the next edge. After reset is released, a button still held is seen as a fresh rise once it has debounced.
- **Press latency:** raw press → synced level after 2 cycles → debounced level on the `DEBOUNCE_MS`-th `ms_tick`. The FSM registers the step on the clk edge after the debounced rise. `timer_upper_bound` and `period_changed` update on that same edge.
- **Output registers:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Glitches:** a glitch shorter than `DEBOUNCE_MS` ticks never changes the debounced level.

## Structure
- **Package `blink_pkg`:** FSM state enum, direction enum, and a default `TICKS_PER_MS` constant shared with `led_blink_module` so the two stages agree on the ms unit.
- **Sub-module `button_debouncer`:** one synchroniser, stability counter and rise/fall strobes. Instantiated twice; takes `ms_tick` as an input.
- **Top level:** tick generator, FSM, saturating period register.

## Test plan
All scenarios use `TICKS_PER_MS`=10, `DEBOUNCE_MS`=2, `REPEAT_DELAY_MS`=5, `REPEAT_RATE_MS`=2, MIN=50, MAX=200, STEP=50, INIT=100.
1. **Reset:** reset held for 3 cycles → `timer_upper_bound`=100, `period_changed`=0, `at_limit`=0.
2. **Single press:** `btn_up` held steady for 40 cycles, then released → period 150, exactly one `period_changed` pulse.
3. **Glitch rejection:** `btn_down` pulses of 15 cycles (<2 ms) → period stays 100, no pulse.
4. **Saturating auto-repeat:** `btn_up` held for 200 cycles → sequence 150, 200, then `at_limit`=1. Further repeats produce no pulses; no value ever exceeds 200.
5. **Both-button restore:** from period 200, press both buttons → period 100. While both stay held, no steps occur. After release and a fresh press, normal stepping resumes.
6. **Reset mid-hold:** in REPEAT at 50, assert `reset` → next cycle period 100 and FSM IDLE. The still-held button produces a new step only after re-debouncing.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and helpers for the button-driven blink period controller.
// The default ms tick length is shared with led_blink_module so both stages agree on the unit.
package blink_pkg;

    localparam int unsigned DEFAULT_TICKS_PER_MS = 100000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD_DELAY,
        ST_REPEAT,
        ST_WAIT_RELEASE
    } state_e;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_e;

    // Saturating step; the 33-bit sums keep the bounds check free of wrap-around.
    function automatic logic [31:0] step_period(
        input logic [31:0] period,
        input dir_e        dir,
        input logic [31:0] p_min,
        input logic [31:0] p_max,
        input logic [31:0] p_step
    );
        logic [32:0] sum;
        logic [32:0] down_floor;
        sum        = {1'b0, period} + {1'b0, p_step};
        down_floor = {1'b0, p_min} + {1'b0, p_step};
        if (dir == DIR_UP) begin
            return (sum > {1'b0, p_max}) ? p_max : sum[31:0];
        end
        return ({1'b0, period} < down_floor) ? p_min : period - p_step;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus ms-tick stability counter for one raw push-button,
// with one-cycle rise/fall strobes taken from the debounced level.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic ms_tick,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (ms_tick) begin
            if (cnt_q == CNT_W'(DEBOUNCE_MS - 1)) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_prev_q;
    assign fall  = ~level_q & level_prev_q;

endmodule

// File: rtl/blink_period_ctrl.sv
// Turns two raw buttons into the registered blink half-period (ms) for led_blink_module:
// debounce, saturating step, hold-to-repeat, and both-buttons restore.
module blink_period_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned TICKS_PER_MS    = DEFAULT_TICKS_PER_MS,
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned PERIOD_MIN      = 50,
    parameter int unsigned PERIOD_MAX      = 2000,
    parameter int unsigned PERIOD_STEP     = 50,
    parameter int unsigned PERIOD_INIT     = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    output logic [31:0] timer_upper_bound,
    output logic        period_changed,
    output logic        at_limit
);

    localparam int unsigned TICK_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS
                                                                          : REPEAT_RATE_MS;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [31:0] P_MIN    = 32'(PERIOD_MIN);
    localparam logic [31:0] P_MAX    = 32'(PERIOD_MAX);
    localparam logic [31:0] P_STEP   = 32'(PERIOD_STEP);
    localparam logic [31:0] P_INIT   = 32'(PERIOD_INIT);
    localparam logic        AT_LIMIT_INIT = (P_INIT == P_MIN) || (P_INIT == P_MAX);

    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              ms_tick;

    logic up_level, up_rise, up_fall;
    logic down_level, down_rise, down_fall;

    state_e            state_q, state_d;
    dir_e              dir_q, dir_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [31:0]       period_q, period_d;
    logic              period_changed_q, period_changed_d;
    logic              at_limit_q, at_limit_d;
    logic              latched_fall;

    assign ms_tick = (tick_cnt_q == TICK_W'(TICKS_PER_MS - 1));

    always_comb begin
        tick_cnt_d = ms_tick ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_up (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_up),
        .ms_tick (ms_tick),
        .level   (up_level),
        .rise    (up_rise),
        .fall    (up_fall)
    );

    button_debouncer #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_deb_down (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_down),
        .ms_tick (ms_tick),
        .level   (down_level),
        .rise    (down_rise),
        .fall    (down_fall)
    );

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        hold_cnt_d   = hold_cnt_q;
        period_d     = period_q;
        latched_fall = (dir_q == DIR_UP) ? up_fall : down_fall;

        // Both buttons down overrides whatever the FSM was doing.
        if (up_level && down_level) begin
            state_d    = ST_WAIT_RELEASE;
            hold_cnt_d = '0;
            period_d   = P_INIT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (up_rise && !down_level) begin
                        dir_d      = DIR_UP;
                        period_d   = step_period(period_q, DIR_UP, P_MIN, P_MAX, P_STEP);
                        hold_cnt_d = '0;
                        state_d    = ST_HOLD_DELAY;
                    end else if (down_rise && !up_level) begin
                        dir_d      = DIR_DOWN;
                        period_d   = step_period(period_q, DIR_DOWN, P_MIN, P_MAX, P_STEP);
                        hold_cnt_d = '0;
                        state_d    = ST_HOLD_DELAY;
                    end
                end
                ST_HOLD_DELAY, ST_REPEAT: begin
                    if (latched_fall) begin
                        hold_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else if (ms_tick) begin
                        if (hold_cnt_q == ((state_q == ST_HOLD_DELAY) ? HOLD_W'(REPEAT_DELAY_MS - 1)
                                                                      : HOLD_W'(REPEAT_RATE_MS - 1))) begin
                            period_d   = step_period(period_q, dir_q, P_MIN, P_MAX, P_STEP);
                            hold_cnt_d = '0;
                            state_d    = ST_REPEAT;
                        end else begin
                            hold_cnt_d = hold_cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (!up_level && !down_level) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        period_changed_d = (period_d != period_q);
        at_limit_d       = (period_d == P_MIN) || (period_d == P_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            dir_q            <= DIR_UP;
            hold_cnt_q       <= '0;
            period_q         <= P_INIT;
            period_changed_q <= 1'b0;
            at_limit_q       <= AT_LIMIT_INIT;
        end else begin
            state_q          <= state_d;
            dir_q            <= dir_d;
            hold_cnt_q       <= hold_cnt_d;
            period_q         <= period_d;
            period_changed_q <= period_changed_d;
            at_limit_q       <= at_limit_d;
        end
    end

    assign timer_upper_bound = period_q;
    assign period_changed    = period_changed_q;
    assign at_limit          = at_limit_q;

endmodule

// File: tb/tb_blink_period_ctrl.sv
// Scoreboard bench for blink_period_ctrl: stimulus queues expected (period, at_limit) pairs,
// a negedge monitor pops one per period_changed pulse and compares.
module tb_blink_period_ctrl;
    import blink_pkg::*;

    typedef struct packed {
        logic [31:0] period;
        logic        at_limit;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        btn_up;
    logic        btn_down;
    logic [31:0] timer_upper_bound;
    logic        period_changed;
    logic        at_limit;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] max_seen = 32'd0;
    int          tb_tick_cnt = 0;

    blink_period_ctrl #(
        .TICKS_PER_MS    (10),
        .DEBOUNCE_MS     (2),
        .REPEAT_DELAY_MS (5),
        .REPEAT_RATE_MS  (2),
        .PERIOD_MIN      (50),
        .PERIOD_MAX      (200),
        .PERIOD_STEP     (50),
        .PERIOD_INIT     (100)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .btn_up            (btn_up),
        .btn_down          (btn_down),
        .timer_upper_bound (timer_upper_bound),
        .period_changed    (period_changed),
        .at_limit          (at_limit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ms tick phase: counter restarts at 0 on reset, tick when it reads 9.
    always @(posedge clk) begin
        if (reset) tb_tick_cnt <= 0;
        else       tb_tick_cnt <= (tb_tick_cnt == 9) ? 0 : tb_tick_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [31:0] period, input logic lim);
        exp_t e;
        e.period   = period;
        e.at_limit = lim;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        check({"drain_", name}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    // Start a pulse so its synchronised window begins two cycles after a tick:
    // 15 cycles then spans exactly one ms tick.
    task automatic aligned_down_glitch();
        for (int i = 0; i < 20 && tb_tick_cnt != 9; i++) @(negedge clk);
        btn_down = 1'b1;
        cycles(15);
        btn_down = 1'b0;
        cycles(20);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (timer_upper_bound > max_seen) max_seen = timer_upper_bound;
            if (period_changed) begin
                check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("pulse_period", timer_upper_bound, mon_e.period);
                    check("pulse_at_limit", 32'(at_limit), 32'(mon_e.at_limit));
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;

        // Reset
        cycles(3);
        check("reset_period", timer_upper_bound, 32'd100);
        check("reset_changed", 32'(period_changed), 32'd0);
        check("reset_at_limit", 32'(at_limit), 32'd0);
        reset = 1'b0;

        // Single press: one step up, hold too short to reach auto-repeat
        expect_pulse(32'd150, 1'b0);
        btn_up = 1'b1;
        cycles(40);
        btn_up = 1'b0;
        cycles(60);
        drain("single");
        check("single_period", timer_upper_bound, 32'd150);

        // Glitch rejection on btn_down
        apply_reset();
        aligned_down_glitch();
        aligned_down_glitch();
        cycles(30);
        check("glitch_period", timer_upper_bound, 32'd100);
        check("glitch_at_limit", 32'(at_limit), 32'd0);

        // Saturating auto-repeat up to MAX
        expect_pulse(32'd150, 1'b0);
        expect_pulse(32'd200, 1'b1);
        btn_up = 1'b1;
        cycles(200);
        check("repeat_period", timer_upper_bound, 32'd200);
        check("repeat_at_limit", 32'(at_limit), 32'd1);
        btn_up = 1'b0;
        cycles(40);
        drain("repeat");
        check("max_period_seen", max_seen, 32'd200);

        // Both buttons restore INIT, no steps while held, stepping resumes afterwards
        expect_pulse(32'd100, 1'b0);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cycles(100);
        check("both_period", timer_upper_bound, 32'd100);
        check("both_state", 32'(dut.state_q), 32'(ST_WAIT_RELEASE));
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cycles(40);
        drain("both");
        expect_pulse(32'd50, 1'b1);
        btn_down = 1'b1;
        cycles(40);
        btn_down = 1'b0;
        cycles(60);
        drain("resume");
        check("resume_period", timer_upper_bound, 32'd50);

        // Reset while auto-repeating at MIN
        btn_down = 1'b1;
        cycles(120);
        check("hold_state", 32'(dut.state_q), 32'(ST_REPEAT));
        check("hold_period", timer_upper_bound, 32'd50);
        reset = 1'b1;
        cycles(1);
        check("midreset_period", timer_upper_bound, 32'd100);
        check("midreset_changed", 32'(period_changed), 32'd0);
        check("midreset_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        cycles(15);
        check("no_early_step", timer_upper_bound, 32'd100);
        expect_pulse(32'd50, 1'b1);
        cycles(40);
        btn_down = 1'b0;
        cycles(60);
        drain("after_reset");
        check("after_reset_period", timer_upper_bound, 32'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
